// File: rtl/tile_dispatcher_pkg.sv
// Shared types and constants for the tile dispatcher: fixed-point vertices, dispatch metadata,
// tile geometry and the dispatcher state encoding.
package tile_dispatcher_pkg;

  localparam int FX_FRAC_BITS      = 4;
  localparam int COORD_BITS        = 16;
  localparam int COLOR_BITS        = 4;
  localparam int TILE_WIDTH        = 16;
  localparam int TILE_SHIFT        = 4;
  localparam int TILE_COLUMNS_BITS = 6;
  localparam int TILE_ROWS_BITS    = 5;

  typedef struct packed {
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
    logic signed [COORD_BITS-1:0] z;
  } coord_3d_t;

  typedef struct packed {
    logic [COLOR_BITS-1:0]        color;
    logic [TILE_COLUMNS_BITS-1:0] tile_x;
    logic [TILE_ROWS_BITS-1:0]    tile_y;
  } metadata_t;

  typedef enum logic [1:0] {IDLE, SETUP, EMIT, FLUSH} disp_state_t;

  // Builds a fixed-point vertex from integer pixel coordinates.
  function automatic coord_3d_t fx_vertex(input int x, input int y, input int z);
    coord_3d_t c;
    c.x = COORD_BITS'(x <<< FX_FRAC_BITS);
    c.y = COORD_BITS'(y <<< FX_FRAC_BITS);
    c.z = COORD_BITS'(z <<< FX_FRAC_BITS);
    return c;
  endfunction

endpackage

// File: rtl/tile_dispatcher_if.sv
// Triangle input, flush request and per-tile dispatch port of the tile dispatcher.
interface tile_dispatcher_if;
  import tile_dispatcher_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready. Once a valid is
  // raised it stays high, with its payload frozen, until that edge; ready may toggle freely.
  logic                  tri_vld_in;
  logic                  tri_rdy_out;
  coord_3d_t             tv0, tv1, tv2;
  logic [COLOR_BITS-1:0] tcolor;
  logic                  flush_req;
  logic                  flush_done;
  logic                  vld_out;
  logic                  rdy_in;
  coord_3d_t             v0, v1, v2;
  metadata_t             metadata;
  logic                  tri_drop;

  modport master (
    input  tri_vld_in, tv0, tv1, tv2, tcolor, flush_req, rdy_in,
    output tri_rdy_out, flush_done, vld_out, v0, v1, v2, metadata, tri_drop
  );

  modport slave (
    output tri_vld_in, tv0, tv1, tv2, tcolor, flush_req, rdy_in,
    input  tri_rdy_out, flush_done, vld_out, v0, v1, v2, metadata, tri_drop
  );

endinterface

// File: rtl/tile_dispatcher_bbox.sv
// Combinational tile range of a triangle's bounding box, clamped to the screen, with an
// offscreen flag when no on-screen tile is covered.
module tile_bbox_range
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_TILES_X = 64,
  parameter int NUM_TILES_Y = 32
) (
  input  coord_3d_t                    v0,
  input  coord_3d_t                    v1,
  input  coord_3d_t                    v2,
  output logic [TILE_COLUMNS_BITS-1:0] tx_lo,
  output logic [TILE_COLUMNS_BITS-1:0] tx_hi,
  output logic [TILE_ROWS_BITS-1:0]    ty_lo,
  output logic [TILE_ROWS_BITS-1:0]    ty_hi,
  output logic                         offscreen
);

  typedef logic signed [COORD_BITS-1:0] coord_int_t;

  // Pixel limits: a min coordinate at or past these lies in a tile beyond the screen.
  localparam coord_int_t X_LIMIT = coord_int_t'(NUM_TILES_X * TILE_WIDTH);
  localparam coord_int_t Y_LIMIT = coord_int_t'(NUM_TILES_Y * TILE_WIDTH);

  function automatic coord_int_t int_part(input coord_int_t c);
    return c >>> FX_FRAC_BITS;
  endfunction

  function automatic coord_int_t min3(input coord_int_t a, input coord_int_t b, input coord_int_t c);
    coord_int_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_int_t max3(input coord_int_t a, input coord_int_t b, input coord_int_t c);
    coord_int_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  coord_int_t min_x, max_x, min_y, max_y;
  logic       unused_z;

  assign unused_z = ^{v0.z, v1.z, v2.z};

  always_comb begin
    min_x = min3(int_part(v0.x), int_part(v1.x), int_part(v2.x));
    max_x = max3(int_part(v0.x), int_part(v1.x), int_part(v2.x));
    min_y = min3(int_part(v0.y), int_part(v1.y), int_part(v2.y));
    max_y = max3(int_part(v0.y), int_part(v1.y), int_part(v2.y));

    offscreen = max_x[COORD_BITS-1] || max_y[COORD_BITS-1] ||
                (min_x >= X_LIMIT) || (min_y >= Y_LIMIT);

    // Low ends clamp at 0, high ends at the last tile; offscreen cases never use these values.
    tx_lo = min_x[COORD_BITS-1] ? '0 : min_x[TILE_SHIFT +: TILE_COLUMNS_BITS];
    ty_lo = min_y[COORD_BITS-1] ? '0 : min_y[TILE_SHIFT +: TILE_ROWS_BITS];
    tx_hi = (max_x >= X_LIMIT) ? TILE_COLUMNS_BITS'(NUM_TILES_X - 1)
                               : max_x[TILE_SHIFT +: TILE_COLUMNS_BITS];
    ty_hi = (max_y >= Y_LIMIT) ? TILE_ROWS_BITS'(NUM_TILES_Y - 1)
                               : max_y[TILE_SHIFT +: TILE_ROWS_BITS];
  end

endmodule

// File: rtl/tile_dispatcher.sv
// Scheduler in front of the tile rasterizer: issues one dispatch per tile covered by each
// accepted triangle (row-major, x fastest), plus a colour-0 flush triangle on request.
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_TILES_X  = 64,
  parameter int NUM_TILES_Y  = 32,
  parameter int FLUSH_TILE_X = NUM_TILES_X - 1,
  parameter int FLUSH_TILE_Y = NUM_TILES_Y - 1
) (
  input  logic               clk,
  input  logic               rst,
  tile_dispatcher_if.master  bus,
  output disp_state_t        dbg_state
);

  localparam coord_3d_t FLUSH_V0 = fx_vertex(0, 0, 128);
  localparam coord_3d_t FLUSH_V1 = fx_vertex(0, 1, 128);
  localparam coord_3d_t FLUSH_V2 = fx_vertex(1, 0, 128);

  disp_state_t                  state;
  logic [TILE_COLUMNS_BITS-1:0] tx_lo, tx_hi;
  logic [TILE_ROWS_BITS-1:0]    ty_lo, ty_hi;
  logic                         offscreen;

  // The latched vertices stay frozen through EMIT, so the range below is stable there too.
  tile_bbox_range #(
    .NUM_TILES_X (NUM_TILES_X),
    .NUM_TILES_Y (NUM_TILES_Y)
  ) u_bbox (
    .v0        (bus.v0),
    .v1        (bus.v1),
    .v2        (bus.v2),
    .tx_lo     (tx_lo),
    .tx_hi     (tx_hi),
    .ty_lo     (ty_lo),
    .ty_hi     (ty_hi),
    .offscreen (offscreen)
  );

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.tri_rdy_out <= 1'b0;
      bus.vld_out     <= 1'b0;
      bus.flush_done  <= 1'b0;
      bus.tri_drop    <= 1'b0;
      bus.v0          <= '0;
      bus.v1          <= '0;
      bus.v2          <= '0;
      bus.metadata    <= '0;
    end else begin
      bus.flush_done <= 1'b0;
      bus.tri_drop   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tri_vld_in && bus.tri_rdy_out) begin
            bus.v0          <= bus.tv0;
            bus.v1          <= bus.tv1;
            bus.v2          <= bus.tv2;
            bus.metadata    <= '{color: bus.tcolor, tile_x: '0, tile_y: '0};
            bus.tri_rdy_out <= 1'b0;
            state           <= SETUP;
          end else if (bus.flush_req && !bus.flush_done) begin
            // flush_done still high means the requester has not yet seen it and dropped the level.
            bus.v0          <= FLUSH_V0;
            bus.v1          <= FLUSH_V1;
            bus.v2          <= FLUSH_V2;
            bus.metadata    <= '{color:  '0,
                                 tile_x: TILE_COLUMNS_BITS'(FLUSH_TILE_X),
                                 tile_y: TILE_ROWS_BITS'(FLUSH_TILE_Y)};
            bus.vld_out     <= 1'b1;
            bus.tri_rdy_out <= 1'b0;
            state           <= FLUSH;
          end else begin
            bus.tri_rdy_out <= 1'b1;
          end
        end
        SETUP: begin
          if (offscreen) begin
            bus.tri_drop    <= 1'b1;
            bus.tri_rdy_out <= 1'b1;
            state           <= IDLE;
          end else begin
            bus.metadata.tile_x <= tx_lo;
            bus.metadata.tile_y <= ty_lo;
            bus.vld_out         <= 1'b1;
            state               <= EMIT;
          end
        end
        EMIT: begin
          if (bus.rdy_in) begin
            if (bus.metadata.tile_x < tx_hi) begin
              bus.metadata.tile_x <= bus.metadata.tile_x + 1'b1;
            end else if (bus.metadata.tile_y < ty_hi) begin
              bus.metadata.tile_x <= tx_lo;
              bus.metadata.tile_y <= bus.metadata.tile_y + 1'b1;
            end else begin
              bus.vld_out     <= 1'b0;
              bus.tri_rdy_out <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (bus.rdy_in) begin
            bus.vld_out     <= 1'b0;
            bus.flush_done  <= 1'b1;
            bus.tri_rdy_out <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_dispatcher.sv
// Bench for tile_dispatcher: vector table, hand-written corner sequences and random triangles
// scored against a pixel/tile arithmetic model of the expected dispatch stream.
module tb_tile_dispatcher;
  import tile_dispatcher_pkg::*;

  localparam int NX = 64;
  localparam int NY = 32;
  localparam int FX = 1 << FX_FRAC_BITS;
  localparam int PW = $bits(metadata_t) + 3 * $bits(coord_3d_t);

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  disp_state_t dbg_state;

  always #5 clk = ~clk;

  tile_dispatcher_if bus();

  tile_dispatcher #(
    .NUM_TILES_X  (NX),
    .NUM_TILES_Y  (NY),
    .FLUSH_TILE_X (NX - 1),
    .FLUSH_TILE_Y (NY - 1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int             n_cmp   = 0;
  int             n_fail  = 0;
  int             n_disp  = 0;
  int             n_drop  = 0;
  int             n_fdone = 0;
  bit             rdy_rand = 1'b0;
  bit             prev_stall = 1'b0;
  logic [PW-1:0]  exp_q[$];

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int color;
    int exp_n;
    bit exp_drop;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic coord_3d_t mk(input int x, input int y, input int z);
    coord_3d_t c;
    c.x = COORD_BITS'(x);
    c.y = COORD_BITS'(y);
    c.z = COORD_BITS'(z);
    return c;
  endfunction

  // Pushes every expected dispatch of one triangle (raw fixed-point inputs); returns the count.
  function automatic int model_push(input coord_3d_t c0, input coord_3d_t c1, input coord_3d_t c2,
                                    input int color);
    int tx_lo, tx_hi, ty_lo, ty_hi, n;
    metadata_t m;
    tx_lo = floor_div(floor_div(imin3(int'(c0.x), int'(c1.x), int'(c2.x)), FX), TILE_WIDTH);
    tx_hi = floor_div(floor_div(imax3(int'(c0.x), int'(c1.x), int'(c2.x)), FX), TILE_WIDTH);
    ty_lo = floor_div(floor_div(imin3(int'(c0.y), int'(c1.y), int'(c2.y)), FX), TILE_WIDTH);
    ty_hi = floor_div(floor_div(imax3(int'(c0.y), int'(c1.y), int'(c2.y)), FX), TILE_WIDTH);
    if (tx_lo < 0) tx_lo = 0;
    if (ty_lo < 0) ty_lo = 0;
    if (tx_hi > NX - 1) tx_hi = NX - 1;
    if (ty_hi > NY - 1) ty_hi = NY - 1;
    n = 0;
    for (int ty = ty_lo; ty <= ty_hi; ty++) begin
      for (int tx = tx_lo; tx <= tx_hi; tx++) begin
        m.color  = COLOR_BITS'(color);
        m.tile_x = TILE_COLUMNS_BITS'(tx);
        m.tile_y = TILE_ROWS_BITS'(ty);
        exp_q.push_back({m, c0, c1, c2});
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] flush_payload();
    metadata_t m;
    m.color  = '0;
    m.tile_x = TILE_COLUMNS_BITS'(NX - 1);
    m.tile_y = TILE_ROWS_BITS'(NY - 1);
    return {m, mk(0, 0, 128 * FX), mk(0, FX, 128 * FX), mk(FX, 0, 128 * FX)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !bus.vld_out) check("vld_held", PW'(bus.vld_out), PW'(1));
      if (bus.vld_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dispatch", {bus.metadata, bus.v0, bus.v1, bus.v2}, '0);
        end else begin
          check("payload", {bus.metadata, bus.v0, bus.v1, bus.v2}, exp_q[0]);
          if (bus.rdy_in) begin
            void'(exp_q.pop_front());
            n_disp++;
          end
        end
      end
      prev_stall = bus.vld_out && !bus.rdy_in;
      if (bus.tri_drop) n_drop++;
      if (bus.flush_done) n_fdone++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) bus.rdy_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int color, output int n_exp);
    int guard;
    coord_3d_t c0, c1, c2;
    c0 = mk(x0, y0, int'($urandom_range(0, 4095)));
    c1 = mk(x1, y1, int'($urandom_range(0, 4095)));
    c2 = mk(x2, y2, int'($urandom_range(0, 4095)));
    n_exp = model_push(c0, c1, c2, color);
    bus.tv0 = c0;
    bus.tv1 = c1;
    bus.tv2 = c2;
    bus.tcolor = COLOR_BITS'(color);
    bus.tri_vld_in = 1'b1;
    guard = 0;
    while (!bus.tri_rdy_out && guard < 200) begin
      tick();
      guard++;
    end
    check("accept_timeout", PW'(guard >= 200), '0);
    tick();
    bus.tri_vld_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !bus.tri_rdy_out) && guard < 6000) begin
      tick();
      guard++;
    end
    check(name, PW'(guard >= 6000), '0);
  endtask

  task automatic wait_flush_done(output int guard);
    guard = 0;
    while (!bus.flush_done && guard < 200) begin
      tick();
      guard++;
    end
    bus.flush_req = 1'b0;
  endtask

  function automatic int px(input int p);
    return p * FX;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int n, d0, r0, f0, g, total;
    bus.tri_vld_in = 1'b0;
    bus.tv0 = '0;
    bus.tv1 = '0;
    bus.tv2 = '0;
    bus.tcolor = '0;
    bus.flush_req = 1'b0;
    bus.rdy_in = 1'b1;

    vecs[0]  = '{px(1), px(1), px(1), px(5), px(5), px(1), 4, 1, 1'b0};
    vecs[1]  = '{px(0), px(0), px(0), px(31), px(31), px(0), 1, 4, 1'b0};
    vecs[2]  = '{px(-40), px(-5), px(-20), px(-9), px(-30), px(-1), 2, 0, 1'b1};
    vecs[3]  = '{px(1020), px(10), px(1100), px(10), px(1020), px(31), 3, 2, 1'b0};
    vecs[4]  = '{px(0), px(0), px(1023), px(0), px(0), px(511), 5, 2048, 1'b0};
    vecs[5]  = '{px(-100), px(-100), px(2000), px(-100), px(-100), px(1000), 6, 2048, 1'b0};
    vecs[6]  = '{px(100), px(100), px(100), px(100), px(100), px(100), 7, 1, 1'b0};
    vecs[7]  = '{px(1024), px(5), px(1030), px(5), px(1024), px(9), 8, 0, 1'b1};
    vecs[8]  = '{-8, 0, -1, 16, -16, 32, 9, 0, 1'b1};
    vecs[9]  = '{px(16), -50, px(47), 0, px(16), -1, 10, 2, 1'b0};
    vecs[10] = '{px(1023), px(511), px(1023), px(511), px(1008), px(496), 11, 1, 1'b0};
    vecs[11] = '{px(0), px(512), px(5), px(512), px(0), px(600), 12, 0, 1'b1};
    vecs[12] = '{px(15), px(15), px(16), px(16), px(15), px(16), 13, 4, 1'b0};

    // Reset values
    repeat (3) tick();
    check("rst_tri_rdy", PW'(bus.tri_rdy_out), '0);
    check("rst_vld", PW'(bus.vld_out), '0);
    check("rst_flush_done", PW'(bus.flush_done), '0);
    check("rst_tri_drop", PW'(bus.tri_drop), '0);
    check("rst_payload", {bus.metadata, bus.v0, bus.v1, bus.v2}, '0);
    check("rst_state", PW'(dbg_state), PW'(IDLE));
    rst = 1'b0;
    tick();
    check("rdy_after_rst", PW'(bus.tri_rdy_out), PW'(1));

    // Latency: accept edge -> SETUP, next edge -> vld_out
    send_tri(px(1), px(1), px(1), px(5), px(5), px(1), 4, n);
    check("lat_setup_state", PW'(dbg_state), PW'(SETUP));
    check("lat_vld_low", PW'(bus.vld_out), '0);
    tick();
    check("lat_vld_high", PW'(bus.vld_out), PW'(1));
    wait_drain("lat_drain");

    // Vector table
    for (int i = 0; i < 13; i++) begin
      d0 = n_disp;
      r0 = n_drop;
      send_tri(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2,
               vecs[i].color, n);
      wait_drain("vec_drain");
      tick();
      check($sformatf("vec%0d_count", i), PW'(n_disp - d0), PW'(vecs[i].exp_n));
      check($sformatf("vec%0d_drop", i), PW'(n_drop - r0), PW'(vecs[i].exp_drop));
    end

    // Four tiles in consecutive cycles, tri_rdy_out back right after the last handshake
    send_tri(px(0), px(0), px(0), px(31), px(31), px(0), 1, n);
    tick();
    repeat (4) tick();
    check("b2b_queue_empty", PW'(exp_q.size()), '0);
    check("b2b_tri_rdy", PW'(bus.tri_rdy_out), PW'(1));

    // Stall at the second tile for 5 cycles
    d0 = n_disp;
    send_tri(px(0), px(0), px(0), px(31), px(31), px(0), 1, n);
    tick();
    tick();
    bus.rdy_in = 1'b0;
    repeat (5) tick();
    check("stall_vld_held", PW'(bus.vld_out), PW'(1));
    bus.rdy_in = 1'b1;
    repeat (3) tick();
    check("stall_queue_empty", PW'(exp_q.size()), '0);
    check("stall_count", PW'(n_disp - d0), PW'(4));

    // Flush alone
    f0 = n_fdone;
    d0 = n_disp;
    exp_q.push_back(flush_payload());
    bus.flush_req = 1'b1;
    wait_flush_done(g);
    check("flush_timeout", PW'(g >= 200), '0);
    tick();
    tick();
    check("flush_done_pulses", PW'(n_fdone - f0), PW'(1));
    check("flush_count", PW'(n_disp - d0), PW'(1));

    // Triangle and flush in the same cycle: triangle tiles first
    f0 = n_fdone;
    d0 = n_disp;
    bus.flush_req = 1'b1;
    send_tri(px(0), px(0), px(0), px(31), px(31), px(0), 1, n);
    exp_q.push_back(flush_payload());
    wait_flush_done(g);
    check("tri_flush_timeout", PW'(g >= 200), '0);
    tick();
    tick();
    check("tri_flush_done", PW'(n_fdone - f0), PW'(1));
    check("tri_flush_count", PW'(n_disp - d0), PW'(5));
    check("tri_flush_queue", PW'(exp_q.size()), '0);

    // Reset after the second handshake aborts the rest
    send_tri(px(0), px(0), px(0), px(31), px(31), px(0), 1, n);
    tick();
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("midrst_vld", PW'(bus.vld_out), '0);
    d0 = n_disp;
    tick();
    check("midrst_tri_rdy", PW'(bus.tri_rdy_out), PW'(1));
    repeat (6) tick();
    check("midrst_no_dispatch", PW'(n_disp - d0), '0);

    // Random triangles with random backpressure and occasional flushes
    rdy_rand = 1'b1;
    total = 0;
    d0 = n_disp;
    for (int i = 0; i < 24; i++) begin
      int cx, cy;
      cx = int'($urandom_range(0, 1300 * FX)) - 150 * FX;
      cy = int'($urandom_range(0, 700 * FX)) - 100 * FX;
      send_tri(cx, cy,
               cx + int'($urandom_range(0, 100 * FX)), cy + int'($urandom_range(0, 60 * FX)),
               cx - int'($urandom_range(0, 40 * FX)), cy + int'($urandom_range(0, 100 * FX)),
               int'($urandom_range(0, 15)), n);
      total += n;
      wait_drain("rand_drain");
      if (i % 6 == 5) begin
        exp_q.push_back(flush_payload());
        total++;
        bus.flush_req = 1'b1;
        wait_flush_done(g);
        check("rand_flush_timeout", PW'(g >= 200), '0);
        tick();
      end
    end
    tick();
    check("rand_total", PW'(n_disp - d0), PW'(total));
    rdy_rand = 1'b0;
    bus.rdy_in = 1'b1;

    check("final_queue_empty", PW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
